// File: rtl/store_merge_unit_pkg.sv
// ============================================================================
// store_merge_unit_pkg : op encodings, FSM states, lane selects for store merge
// Revision: 1.0
// ============================================================================
`default_nettype none

package store_merge_unit_pkg;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_SB   = 2'b01;
  localparam logic [1:0] OP_SH   = 2'b10;
  localparam logic [1:0] OP_SW   = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_READ  = 3'd1;
  localparam state_t ST_MERGE = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_FAULT = 3'd4;

  // Big-endian byte lanes: lane k sits at bits [31-8k -: 8]
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;
  // addr[1] value selecting the upper halfword [31:16]
  localparam logic       HALF_HI = 1'b0;

  function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] addr_lo);
    return ((op == OP_SH) && addr_lo[0]) || ((op == OP_SW) && (addr_lo != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_lane_merge.sv
// ============================================================================
// store_lane_merge : combinational insert of a byte/halfword lane into a word
// Revision: 1.0
// ============================================================================
`default_nettype none

module store_lane_merge
  import store_merge_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  op,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    case (op)
      OP_SB: begin
        case (addr_lo)
          LANE_B0: merged[31:24] = data[7:0];
          LANE_B1: merged[23:16] = data[7:0];
          LANE_B2: merged[15:8]  = data[7:0];
          LANE_B3: merged[7:0]   = data[7:0];
          default: merged = old_word;
        endcase
      end
      OP_SH: begin
        if (addr_lo[1] == HALF_HI) merged[31:16] = data[15:0];
        else                       merged[15:0]  = data[15:0];
      end
      OP_SW:   merged = data;
      default: merged = old_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/store_merge_unit.sv
// ============================================================================
// store_merge_unit : SW pass-through, SB/SH read-modify-write store engine
// Revision: 1.0
// ============================================================================
`default_nettype none

module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          misalign
);

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] merged_w;

  store_lane_merge u_lane_merge (
    .old_word (mem_rdata),
    .data     (data_q),
    .op       (op_q),
    .addr_lo  (addr_q[1:0]),
    .merged   (merged_w)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && (req_op != OP_NONE)) begin
          op_d   = req_op;
          addr_d = req_addr;
          data_d = req_data;
          if (is_misaligned(req_op, req_addr[1:0])) begin
            state_d = ST_FAULT;
          end else if (req_op == OP_SW) begin
            wdata_d = req_data;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ:  state_d = ST_MERGE;
      ST_MERGE: begin
        wdata_d = merged_w;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
    end
  end

  // Strobes decode from state only, so req_* never reaches mem_* combinationally
  assign mem_addr  = {addr_q[AW-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_rd_en = (state_q == ST_READ);
  assign mem_wr_en = (state_q == ST_WRITE);
  assign done      = (state_q == ST_WRITE) || (state_q == ST_FAULT);
  assign misalign  = (state_q == ST_FAULT);
  assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_store_merge_unit.sv
// ============================================================================
// tb_store_merge_unit : directed bench for store_merge_unit with word memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        misalign;

  logic [31:0] mem [0:255];
  logic        init_mem;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          snap;

  always #5 clk = ~clk;

  store_merge_unit #(.AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .misalign  (misalign)
  );

  // Word memory: one-cycle read latency, preload on init_mem
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr[9:2]];
    if (init_mem) begin
      mem[8'h40] <= 32'h1122_3344;
      mem[8'h41] <= 32'h0000_0000;
    end else if (mem_wr_en) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    rd_cnt <= rd_cnt + (mem_rd_en ? 1 : 0);
    wr_cnt <= wr_cnt + (mem_wr_en ? 1 : 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic init_words();
    init_mem = 1'b1;
    tick();
    init_mem = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
  endtask

  task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
    chk({tag, "_wr_en"},    {31'd0, mem_wr_en}, 32'd1);
    chk({tag, "_done"},     {31'd0, done},      32'd1);
    chk({tag, "_misalign"}, {31'd0, misalign},  32'd0);
    chk({tag, "_rd_en"},    {31'd0, mem_rd_en}, 32'd0);
    chk({tag, "_addr"},     mem_addr,           addr);
    chk({tag, "_wdata"},    mem_wdata,          wdata);
  endtask

  task automatic expect_quiet(input string tag);
    chk({tag, "_busy"},  {31'd0, busy},      32'd0);
    chk({tag, "_done"},  {31'd0, done},      32'd0);
    chk({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
  endtask

  task automatic run_rmw(input string tag, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_word);
    init_words();
    issue(op, addr, data);
    tick();
    req_valid = 1'b0;
    chk({tag, "_read_rd_en"}, {31'd0, mem_rd_en}, 32'd1);
    chk({tag, "_read_addr"},  mem_addr,           {addr[31:2], 2'b00});
    chk({tag, "_read_busy"},  {31'd0, busy},      32'd1);
    chk({tag, "_read_done"},  {31'd0, done},      32'd0);
    tick();
    chk({tag, "_merge_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
    chk({tag, "_merge_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
    tick();
    expect_write(tag, {addr[31:2], 2'b00}, exp_word);
    tick();
    expect_quiet({tag, "_after"});
    chk({tag, "_mem"}, mem[addr[9:2]], exp_word);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    init_mem  = 1'b1;
    tick();
    chk("rst_mem_addr",  mem_addr,            32'h0);
    chk("rst_mem_wdata", mem_wdata,           32'h0);
    chk("rst_misalign",  {31'd0, misalign},   32'd0);
    expect_quiet("rst");
    tick();
    #2 reset = 1'b0;
    init_mem = 1'b0;
    tick();

    // op 00 with valid is ignored
    issue(2'b00, 32'h100, 32'h1234_5678);
    tick();
    expect_quiet("nop1");
    tick();
    expect_quiet("nop2");
    req_valid = 1'b0;

    // Byte and halfword read-modify-writes
    run_rmw("sb101",   2'b01, 32'h101, 32'hFFFF_FFAB, 32'h11AB_3344);
    run_rmw("sh102",   2'b10, 32'h102, 32'hFFFF_BEEF, 32'h1122_BEEF);
    run_rmw("sh100",   2'b10, 32'h100, 32'h0000_BEEF, 32'hBEEF_3344);
    run_rmw("sb103",   2'b01, 32'h103, 32'h0000_005A, 32'h1122_335A);

    // Aligned SW: single-cycle write, no read
    init_words();
    snap = rd_cnt;
    issue(2'b11, 32'h104, 32'hDEAD_BEEF);
    tick();
    req_valid = 1'b0;
    expect_write("sw104", 32'h104, 32'hDEAD_BEEF);
    tick();
    expect_quiet("sw104_after");
    chk("sw104_mem",    mem[8'h41], 32'hDEAD_BEEF);
    chk("sw104_no_rd",  rd_cnt,     snap);

    // Misaligned SH: fault pulse, no strobes, memory untouched
    init_words();
    snap = wr_cnt;
    issue(2'b10, 32'h103, 32'h0000_BEEF);
    tick();
    req_valid = 1'b0;
    chk("mis_done",     {31'd0, done},      32'd1);
    chk("mis_misalign", {31'd0, misalign},  32'd1);
    chk("mis_busy",     {31'd0, busy},      32'd1);
    chk("mis_rd_en",    {31'd0, mem_rd_en}, 32'd0);
    chk("mis_wr_en",    {31'd0, mem_wr_en}, 32'd0);
    tick();
    expect_quiet("mis_after");
    chk("mis_misalign_clr", {31'd0, misalign}, 32'd0);
    chk("mis_mem",      mem[8'h40], 32'h1122_3344);
    chk("mis_no_wr",    wr_cnt,     snap);

    // Misaligned SW
    issue(2'b11, 32'h106, 32'h1111_2222);
    tick();
    req_valid = 1'b0;
    chk("misw_misalign", {31'd0, misalign},  32'd1);
    chk("misw_wr_en",    {31'd0, mem_wr_en}, 32'd0);
    tick();

    // Reset during MERGE drops the store
    init_words();
    snap = wr_cnt;
    issue(2'b01, 32'h101, 32'h0000_0055);
    tick();
    req_valid = 1'b0;
    tick();
    chk("rstm_busy_merge", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstm_addr",     mem_addr,          32'h0);
    chk("rstm_wdata",    mem_wdata,         32'h0);
    chk("rstm_misalign", {31'd0, misalign}, 32'd0);
    expect_quiet("rstm");
    tick();
    tick();
    #2 reset = 1'b0;
    tick();
    expect_quiet("rstm_post");
    chk("rstm_no_wr", wr_cnt,     snap);
    chk("rstm_mem",   mem[8'h40], 32'h1122_3344);
    issue(2'b11, 32'h104, 32'hCAFE_F00D);
    tick();
    req_valid = 1'b0;
    expect_write("rstm_sw", 32'h104, 32'hCAFE_F00D);
    tick();
    chk("rstm_sw_mem", mem[8'h41], 32'hCAFE_F00D);

    // Back-to-back SB then SW with valid held high
    init_words();
    issue(2'b01, 32'h100, 32'h0000_0099);
    tick();
    chk("b2b_read", {31'd0, mem_rd_en}, 32'd1);
    tick();
    tick();
    expect_write("b2b_sb", 32'h100, 32'h9922_3344);
    issue(2'b11, 32'h104, 32'h1234_5678);
    tick();
    expect_quiet("b2b_idle");
    tick();
    req_valid = 1'b0;
    expect_write("b2b_sw", 32'h104, 32'h1234_5678);
    tick();
    expect_quiet("b2b_end");
    chk("b2b_mem_sb", mem[8'h40], 32'h9922_3344);
    chk("b2b_mem_sw", mem[8'h41], 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
